// File: rtl/logic_gate_array.sv
// Array of independent logic gates, each with an inertial output delay of DELAY enabled cycles.
// Define LOGIC_GATE_ARRAY_TOGGLE_CNT_EN to build the per-channel saturating output-toggle counters.
module logic_gate_array #(
  parameter int CHANNELS = 4,
  parameter int NIN      = 2,
  parameter int DELAY    = 3,
  parameter int CW       = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [3*CHANNELS-1:0]    mode,
  input  logic [NIN*CHANNELS-1:0]  a,
  input  logic                     clr_cnt,
  output logic [CHANNELS-1:0]      y,
  output logic [CHANNELS-1:0]      pend,
  output logic [CW*CHANNELS-1:0]   toggles
);

  typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_t;

  localparam logic [3:0] DLY_M1 = 4'(DELAY - 1);

`ifndef LOGIC_GATE_ARRAY_TOGGLE_CNT_EN
  logic unused_clr;
  assign unused_clr = clr_cnt;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic [NIN-1:0] in_w;
      logic           f;
      state_t         state_q, state_d;
      logic           y_q, y_d;
      logic           tgt_q, tgt_d;
      logic [3:0]     cnt_q, cnt_d;

      assign in_w = a[NIN*gi +: NIN];

      always_comb begin
        f = 1'b0;
        case (mode[3*gi +: 3])
          3'd0: f =  (&in_w);
          3'd1: f = ~(&in_w);
          3'd2: f =  (|in_w);
          3'd3: f = ~(|in_w);
          3'd4: f =  (^in_w);
          3'd5: f = ~(^in_w);
          3'd6: f = ~in_w[0];
          default: f = in_w[0];
        endcase
      end

      // A target that drops back before DELAY enabled edges is discarded (inertial delay).
      always_comb begin
        state_d = state_q;
        y_d     = y_q;
        tgt_d   = tgt_q;
        cnt_d   = cnt_q;
        if (en) begin
          case (state_q)
            IDLE: begin
              if (f != y_q) begin
                if (DELAY == 1) begin
                  y_d = f;
                end else begin
                  state_d = PEND;
                  tgt_d   = f;
                  cnt_d   = 4'd1;
                end
              end
            end
            default: begin
              if (f == tgt_q) begin
                if (cnt_q == DLY_M1) begin
                  y_d     = tgt_q;
                  state_d = IDLE;
                  cnt_d   = 4'd0;
                end else begin
                  cnt_d = cnt_q + 4'd1;
                end
              end else begin
                state_d = IDLE;
                cnt_d   = 4'd0;
              end
            end
          endcase
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          state_q <= IDLE;
          y_q     <= 1'b0;
          tgt_q   <= 1'b0;
          cnt_q   <= 4'd0;
        end else begin
          state_q <= state_d;
          y_q     <= y_d;
          tgt_q   <= tgt_d;
          cnt_q   <= cnt_d;
        end
      end

      assign y[gi]    = y_q;
      assign pend[gi] = (state_q == PEND);

`ifdef LOGIC_GATE_ARRAY_TOGGLE_CNT_EN
      logic [CW-1:0] tog_q, tog_d;

      always_comb begin
        tog_d = tog_q;
        if (clr_cnt) begin
          tog_d = '0;
        end else if ((y_d != y_q) && (tog_q != {CW{1'b1}})) begin
          tog_d = tog_q + 1'b1;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) tog_q <= '0;
        else     tog_q <= tog_d;
      end

      assign toggles[CW*gi +: CW] = tog_q;
`else
      assign toggles[CW*gi +: CW] = '0;
`endif
    end
  endgenerate

endmodule

// File: tb/tb_logic_gate_array.sv
// Randomized bench for logic_gate_array with an in-bench run-length delay model plus literal checks.
// Toggle expectations follow LOGIC_GATE_ARRAY_TOGGLE_CNT_EN the same way the design does.
module tb_logic_gate_array;
  localparam int CH = 4;
  localparam int NI = 2;
  localparam int DL = 3;
  localparam int CWT = 2;
`ifdef LOGIC_GATE_ARRAY_TOGGLE_CNT_EN
  localparam bit TOG_EN = 1'b1;
`else
  localparam bit TOG_EN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic               en;
  logic [3*CH-1:0]    mode;
  logic [NI*CH-1:0]   a;
  logic               clr_cnt;
  logic [CH-1:0]      y;
  logic [CH-1:0]      pend;
  logic [CWT*CH-1:0]  toggles;

  logic_gate_array #(.CHANNELS(CH), .NIN(NI), .DELAY(DL), .CW(CWT)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .clr_cnt(clr_cnt),
    .y(y), .pend(pend), .toggles(toggles)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: an output flips once its gate value has disagreed with it for DL consecutive enabled edges.
  bit ym[CH];
  int run_m[CH];
  int tm[CH];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic bit gate_f(input int md, input int bits);
    int pc;
    pc = (bits & 1) + ((bits >> 1) & 1);
    case (md)
      0: return pc == NI;
      1: return pc != NI;
      2: return pc > 0;
      3: return pc == 0;
      4: return (pc % 2) == 1;
      5: return (pc % 2) == 0;
      6: return (bits & 1) == 0;
      default: return (bits & 1) == 1;
    endcase
  endfunction

  function automatic int exp_tog(input int n);
    return TOG_EN ? n : 0;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      ym[c] = 1'b0;
      run_m[c] = 0;
      tm[c] = 0;
    end
  endtask

  task automatic model_update();
    bit f;
    bit flipped;
    if (rst) return;
    for (int c = 0; c < CH; c++) begin
      flipped = 1'b0;
      if (en) begin
        f = gate_f(int'(mode[3*c +: 3]), int'(a[NI*c +: NI]));
        if (f != ym[c]) begin
          run_m[c]++;
          if (run_m[c] == DL) begin
            ym[c] = f;
            run_m[c] = 0;
            flipped = 1'b1;
          end
        end else begin
          run_m[c] = 0;
        end
      end
      if (clr_cnt) tm[c] = 0;
      else if (flipped && tm[c] < (1 << CWT) - 1) tm[c]++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic set_ch(input int c, input int md, input int bits);
    mode[3*c +: 3] = 3'(md);
    a[NI*c +: NI]  = 2'(bits);
  endtask

  always @(negedge clk) begin
    for (int c = 0; c < CH; c++) begin
      chk($sformatf("cyc_y%0d", c), int'(y[c]), int'(ym[c]));
      chk($sformatf("cyc_pend%0d", c), int'(pend[c]), int'(run_m[c] != 0));
      chk($sformatf("cyc_tog%0d", c), int'(toggles[CWT*c +: CWT]), exp_tog(tm[c]));
    end
  end

  logic [31:0] tt;

  initial begin
    // truth table, index mode*4 + {a1,a0}
    tt = {4'b1010, 4'b0101, 4'b1001, 4'b0110, 4'b0001, 4'b1110, 4'b0111, 4'b1000};
    rst = 1'b1; en = 1'b0; mode = '0; a = '0; clr_cnt = 1'b0;
    model_reset();
    step(); step();
    rst = 1'b0;
    chk("reset_y", int'(y), 0);
    chk("reset_pend", int'(pend), 0);
    chk("reset_tog", int'(toggles), 0);

    // ch0 AND rising through the full delay
    en = 1'b1;
    set_ch(0, 0, 3);
    step(); chk("and_pend_e0", int'(pend[0]), 1); chk("and_y_e0", int'(y[0]), 0);
    step(); chk("and_pend_e1", int'(pend[0]), 1);
    step(); chk("and_y_e2", int'(y[0]), 1); chk("and_pend_e2", int'(pend[0]), 0);
    chk("and_tog", int'(toggles[1:0]), exp_tog(1));

    // ch1 OR short pulse rejected
    set_ch(1, 2, 1);
    step(); step();
    set_ch(1, 2, 0);
    step(); step(); step();
    chk("pulse_y", int'(y[1]), 0);
    chk("pulse_pend", int'(pend[1]), 0);
    chk("pulse_tog", int'(toggles[3:2]), 0);

    // ch2 all modes over all input patterns
    for (int m = 0; m < 8; m++) begin
      for (int p = 0; p < 4; p++) begin
        set_ch(2, m, p);
        step(); step(); step();
        chk($sformatf("tt_m%0d_p%0d", m, p), int'(y[2]), int'(tt[m*4 + p]));
      end
    end

    // ch3 freeze mid-PEND
    set_ch(3, 7, 0);
    step(); step(); step();
    set_ch(3, 7, 1);
    step();
    chk("frz_pend0", int'(pend[3]), 1);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("frz_y", int'(y[3]), 0);
      chk("frz_pend", int'(pend[3]), 1);
    end
    en = 1'b1;
    step(); chk("frz_y_r1", int'(y[3]), 0);
    step(); chk("frz_y_r2", int'(y[3]), 1);

    // reset mid-PEND on ch0 (y currently 1)
    set_ch(0, 0, 0);
    step();
    chk("rstp_pend", int'(pend[0]), 1);
    #2 rst = 1'b1; model_reset();
    #1 chk("rstp_y_now", int'(y[0]), 0); chk("rstp_pend_now", int'(pend[0]), 0);
    set_ch(0, 1, 0);
    rst = 1'b0;
    step(); step(); chk("rstp_y_e1", int'(y[0]), 0);
    step(); chk("rstp_y_e2", int'(y[0]), 1);

    // ch1 toggle saturation then clear on the 6th toggle edge
    for (int k = 1; k <= 5; k++) begin
      set_ch(1, 7, k % 2);
      step(); step(); step();
      chk("sat_y", int'(y[1]), k % 2);
      chk("sat_tog", int'(toggles[3:2]), exp_tog(k < 3 ? k : 3));
    end
    set_ch(1, 7, 0);
    step(); step();
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    chk("clr_y", int'(y[1]), 0);
    chk("clr_tog", int'(toggles[3:2]), 0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 7) == 0)
        mode[3*$urandom_range(0, CH-1) +: 3] = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 2) == 0) a = 8'($urandom);
      clr_cnt = ($urandom_range(0, 40) == 0);
      if ($urandom_range(0, 150) == 0) begin
        #2 rst = 1'b1; model_reset();
        #1 rst = 1'b0;
      end
      step();
    end
    clr_cnt = 1'b0;
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/logic_gate_array.md
LOGIC_GATE_ARRAY -- requirements
Module: logic_gate_array

Interface
REQ-001 SHALL have parameter CHANNELS, default 4: number of independent gate channels (1..16).
REQ-002 SHALL have parameter NIN, default 2: inputs per channel (2..8).
REQ-003 SHALL have parameter DELAY, default 3: inertial propagation delay in clock cycles (1..15).
REQ-004 SHALL have parameter CW, default 16: toggle counter width per channel.
REQ-005 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst  input  1: reset, asynchronous, active-high.
REQ-007 SHALL have port en  input  1: global advance enable; low freezes all state.
REQ-008 SHALL have port mode  input  3*CHANNELS: per-channel gate function; channel c uses bits [3c+2:3c].
REQ-009 SHALL have port a  input  NIN*CHANNELS: gate inputs; channel c uses bits [NIN*c+NIN-1:NIN*c].
REQ-010 SHALL have port clr_cnt  input  1: synchronous clear of all toggle counters.
REQ-011 SHALL have port y  output  CHANNELS: registered, delayed gate outputs.
REQ-012 SHALL have port pend  output  CHANNELS: channel has a transition in flight.
REQ-013 SHALL have port toggles  output  CW*CHANNELS: per-channel output transition counts.

Function
REQ-014 SHALL compute per-channel f from mode: 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR (reductions over all NIN inputs), 6 INV (of input bit 0), 7 BUF (input bit 0).
REQ-015 SHALL implement per channel a two-state FSM: IDLE (pend=0) and PEND (pend=1), with tgt register and cycle counter cnt.
REQ-016 SHALL, in IDLE at an enabled edge with f!=y: if DELAY=1 set y<=f and stay IDLE; else go PEND, tgt<=f, cnt<=1.
REQ-017 SHALL, in PEND at an enabled edge with f==tgt: if cnt==DELAY-1 set y<=tgt, go IDLE, cnt<=0; else cnt<=cnt+1.
REQ-018 SHALL, in PEND at an enabled edge with f!=tgt: go IDLE, cnt<=0, y unchanged (pulse rejected).
REQ-019 SHALL thus update y exactly DELAY enabled edges after f first differs from y, and reject pulses shorter than DELAY enabled cycles.
REQ-020 SHALL treat a mode change like any input change: f is re-evaluated, no separate state reset.
REQ-021 SHALL, when en=0, hold y, pend, cnt, tgt and toggles unchanged; cycles with en=0 do not count toward DELAY.
REQ-022 SHALL increment a channel's toggle counter on each edge where its y changes, saturating at 2^CW-1.
REQ-023 SHALL, when clr_cnt=1, clear all counters at that edge regardless of en; clear wins over a simultaneous increment.
REQ-024 SHALL keep channels fully independent; simultaneous transitions on all channels are handled in the same cycle.

Reset
REQ-025 SHALL, while rst=1, asynchronously force y=0, pend=0, all FSMs IDLE, cnt=0, tgt=0, toggles=0.
REQ-026 SHALL discard any in-flight transition on reset mid-PEND; after release, channels re-evaluate from y=0.

Configuration
REQ-027 SHALL use macro LOGIC_GATE_ARRAY_TOGGLE_CNT_EN: defined, toggle counters and clr_cnt behave per REQ-022/023.
REQ-028 SHALL, without LOGIC_GATE_ARRAY_TOGGLE_CNT_EN, drive toggles constant 0, ignore clr_cnt, instantiate no counters; port list unchanged.

Verification
REQ-029 SHALL cover: CH0 mode=0, a=2'b11 at edge 0, DELAY=3 -> pend=1 edges 0-2, y[0]=1 after edge 2, toggles[0]=1.
REQ-030 SHALL cover: CH1 mode=2, a=2'b01 held 2 cycles then 2'b00, DELAY=3 -> y[1] stays 0, pend returns 0, toggles[1]=0.
REQ-031 SHALL cover: all 8 modes with NIN=2 over all 4 input patterns -> y matches truth table after 3 edges each.
REQ-032 SHALL cover: en=0 for 5 cycles mid-PEND with cnt=1 -> y and pend frozen; y updates 2 enabled edges after en returns.
REQ-033 SHALL cover: rst pulse mid-PEND then mode=1, a=2'b00 -> y=0 immediately on rst, y=1 3 edges after release.
REQ-034 SHALL cover: CW=2, 5 output toggles then clr_cnt coinciding with a 6th -> toggles saturates at 3, then reads 0.
